// File: rtl/homa_tx_msg_prio_reg_if.sv
// Request/response channel between the egress SDNet wrapper and the txMsgPrioReg responder.
interface homa_tx_msg_prio_reg_if;
    logic        txMsgPrioReg_req_valid;
    logic [15:0] txMsgPrioReg_req_bits_index;
    logic        txMsgPrioReg_req_bits_update;
    logic [7:0]  txMsgPrioReg_req_bits_prio;
    logic        txMsgPrioReg_resp_valid;
    logic [7:0]  txMsgPrioReg_resp_bits_prio;

    modport master (
        output txMsgPrioReg_req_valid,
        output txMsgPrioReg_req_bits_index,
        output txMsgPrioReg_req_bits_update,
        output txMsgPrioReg_req_bits_prio,
        input  txMsgPrioReg_resp_valid,
        input  txMsgPrioReg_resp_bits_prio
    );

    modport slave (
        input  txMsgPrioReg_req_valid,
        input  txMsgPrioReg_req_bits_index,
        input  txMsgPrioReg_req_bits_update,
        input  txMsgPrioReg_req_bits_prio,
        output txMsgPrioReg_resp_valid,
        output txMsgPrioReg_resp_bits_prio
    );
endinterface

// File: rtl/homa_tx_msg_prio_reg.sv
// Per-message priority store for the egress txMsgPrioReg extern: read or read-modify-write,
// returning the pre-update priority two cycles after the request.
module homa_tx_msg_prio_reg #(
    parameter int unsigned NUM_ENTRIES  = 128,
    parameter logic [7:0]  DEFAULT_PRIO = 8'd0,
    parameter logic [7:0]  MAX_PRIO     = 8'd7
) (
    input  logic                    clock,
    input  logic                    reset,
    homa_tx_msg_prio_reg_if.slave   net,
    input  logic                    clear_valid,
    input  logic [15:0]             clear_index,
    output logic [15:0]             err_oor_cnt
);

    localparam int unsigned IDX_W  = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int unsigned IN_W   = 16;
    localparam int unsigned PRIO_W = 8;
    localparam int unsigned CNT_W  = 16;

    // Stage-1 request register
    logic              s1_valid;
    logic [IN_W-1:0]   s1_index;
    logic              s1_update;
    logic [PRIO_W-1:0] s1_prio;

    logic [PRIO_W-1:0] mem [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid_q;

    logic              s1_in_range;
    logic [IDX_W-1:0]  s1_addr;
    logic              s1_wr;
    logic [PRIO_W-1:0] wr_prio;
    logic [PRIO_W-1:0] read_val;
    logic              clr_en;
    logic [IDX_W-1:0]  clr_addr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_index  <= '0;
            s1_update <= 1'b0;
            s1_prio   <= '0;
        end else begin
            s1_valid  <= net.txMsgPrioReg_req_valid;
            if (net.txMsgPrioReg_req_valid) begin
                s1_index  <= net.txMsgPrioReg_req_bits_index;
                s1_update <= net.txMsgPrioReg_req_bits_update;
                s1_prio   <= net.txMsgPrioReg_req_bits_prio;
            end
        end
    end

    always_comb begin
        s1_in_range = (32'(s1_index) < NUM_ENTRIES);
        s1_addr     = s1_index[IDX_W-1:0];
        s1_wr       = s1_valid & s1_update & s1_in_range;
        wr_prio     = (s1_prio > MAX_PRIO) ? MAX_PRIO : s1_prio;
        clr_en      = clear_valid & (32'(clear_index) < NUM_ENTRIES);
        clr_addr    = clear_index[IDX_W-1:0];
        read_val    = DEFAULT_PRIO;
        if (s1_in_range && valid_q[s1_addr]) begin
            read_val = mem[s1_addr];
        end
    end

    // Data array carries no reset; the valid vector masks stale contents.
    always_ff @(posedge clock) begin
        if (s1_wr) begin
            mem[s1_addr] <= wr_prio;
        end
    end

    // A stage-1 write to the same slot as a clear takes precedence.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            if (clr_en) begin
                valid_q[clr_addr] <= 1'b0;
            end
            if (s1_wr) begin
                valid_q[s1_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            net.txMsgPrioReg_resp_valid     <= 1'b0;
            net.txMsgPrioReg_resp_bits_prio <= '0;
        end else begin
            net.txMsgPrioReg_resp_valid <= s1_valid;
            if (s1_valid) begin
                net.txMsgPrioReg_resp_bits_prio <= read_val;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_oor_cnt <= '0;
        end else if (s1_valid && !s1_in_range && (err_oor_cnt != {CNT_W{1'b1}})) begin
            err_oor_cnt <= err_oor_cnt + CNT_W'(1);
        end
    end

endmodule
